axi_rd_scheduler: RTL and testbench

AXI_RD_SCHEDULER -- requirements
Module: axi_rd_scheduler

---
 rtl/axi_rd_scheduler.sv | 144 ++++++++++++++
 tb/tb_axi_rd_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_scheduler.sv
// axi_rd_scheduler: two-requester round-robin scheduler that splits each transfer
// into AXI read bursts bounded by MAX_BURST and 4 KB pages, one burst in flight.
module axi_rd_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [15:0]           req0_beats,
  output logic                  req0_ready,
  output logic                  req0_done,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [15:0]           req1_beats,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic                  cmd_id,
  input  logic                  burst_done,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LOG2B = $clog2(BYTES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           remaining;
  logic [8:0]            beats;
  logic                  owner;
  logic                  last;

  logic                  grant_valid;
  logic                  grant_id;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [15:0]           next_rem;
  logic [8:0]            cur_beats;
  logic [8:0]            next_beats;

  // Burst size limited by what is left, MAX_BURST and the distance to the next 4 KB page.
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [15:0] rem);
    logic [12:0] room;
    logic [16:0] n;
    room = (13'd4096 - {1'b0, a[11:0]}) >> LOG2B;
    n    = {1'b0, rem};
    if ({4'd0, room} < n) n = {4'd0, room};
    if (17'(MAX_BURST) < n) n = 17'(MAX_BURST);
    return n[8:0];
  endfunction

  // last==0 means req0 was served last, so req1 wins a tie.
  assign grant_valid = req0_valid | req1_valid;
  assign grant_id    = req1_valid & (~req0_valid | ~last);
  assign grant_addr  = (grant_id ? req1_addr : req0_addr) & ~ADDR_WIDTH'(BYTES - 1);

  assign next_addr  = addr + (ADDR_WIDTH'(beats) << LOG2B);
  assign next_rem   = remaining - 16'(beats);
  assign cur_beats  = burst_beats(addr, remaining);
  assign next_beats = burst_beats(next_addr, next_rem);

  assign cmd_addr  = addr;
  assign cmd_id    = owner;
  assign busy      = (state != IDLE);
  assign req0_done = (state == DONE) & ~owner;
  assign req1_done = (state == DONE) & owner;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      beats      <= '0;
      owner      <= 1'b0;
      last       <= 1'b1;
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_len    <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            req0_ready <= ~grant_id;
            req1_ready <= grant_id;
            addr       <= grant_addr;
            remaining  <= grant_id ? req1_beats : req0_beats;
            owner      <= grant_id;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // First ISSUE cycle after a grant computes the burst; a zero-beat transfer skips to DONE.
          if (!cmd_valid) begin
            if (remaining == 16'd0) begin
              state <= DONE;
            end else begin
              cmd_valid <= 1'b1;
              beats     <= cur_beats;
              cmd_len   <= 8'(cur_beats - 9'd1);
            end
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (burst_done) begin
            addr      <= next_addr;
            remaining <= next_rem;
            if (next_rem == 16'd0) begin
              state <= DONE;
            end else begin
              cmd_valid <= 1'b1;
              beats     <= next_beats;
              cmd_len   <= 8'(next_beats - 9'd1);
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_scheduler.sv
// Directed self-checking bench for axi_rd_scheduler (DATA_WIDTH=64, MAX_BURST=64).
module tb_axi_rd_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_addr = '0;
  logic [15:0] req0_beats = '0;
  logic        req0_ready;
  logic        req0_done;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_addr = '0;
  logic [15:0] req1_beats = '0;
  logic        req1_ready;
  logic        req1_done;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_id;
  logic        burst_done = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axi_rd_scheduler #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_BURST(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_beats(req0_beats),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_beats(req1_beats),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_id(cmd_id), .burst_done(burst_done), .busy(busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_done0"}, req0_done, 0);
    chk({tag, "_done1"}, req1_done, 0);
    chk({tag, "_cmdv"}, cmd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Present one request for a single cycle; afterwards cmd_valid (if any) is due.
  task automatic request(input logic id, input logic [31:0] a, input logic [15:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_addr = a; req1_beats = b;
    end else begin
      req0_valid = 1'b1; req0_addr = a; req0_beats = b;
    end
    tick();
    chk("grant_ready0", req0_ready, !id);
    chk("grant_ready1", req1_ready, id);
    chk("grant_busy", busy, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_addr  = 32'hDEAD_BEE8;
    req1_addr  = 32'hDEAD_BEE8;
    tick();
  endtask

  // Command must be up now; stall one cycle (with a stray burst_done), then accept it.
  task automatic expect_cmd(input string tag, input logic [31:0] a, input logic [7:0] l,
                            input logic id);
    chk({tag, "_valid"}, cmd_valid, 1);
    chk({tag, "_addr"}, cmd_addr, a);
    chk({tag, "_len"}, cmd_len, l);
    chk({tag, "_id"}, cmd_id, id);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk({tag, "_hold_valid"}, cmd_valid, 1);
    chk({tag, "_hold_addr"}, cmd_addr, a);
    chk({tag, "_hold_len"}, cmd_len, l);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk({tag, "_drop"}, cmd_valid, 0);
  endtask

  task automatic finish_burst();
    tick();
    chk("wait_no_cmd", cmd_valid, 0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    chk_idle_outputs("reset");
    chk("reset_addr", cmd_addr, 0);
    chk("reset_len", cmd_len, 0);
    chk("reset_id", cmd_id, 0);
    i_rst_n = 1'b1;
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk_idle_outputs("idle_stray_done");

    // Single 64-beat burst with cmd_ready held high
    cmd_ready  = 1'b1;
    req0_valid = 1'b1; req0_addr = 32'h1000; req0_beats = 16'd64;
    tick();
    chk("t1_ready0", req0_ready, 1);
    chk("t1_cmdv_early", cmd_valid, 0);
    req0_valid = 1'b0;
    tick();
    chk("t1_cmdv", cmd_valid, 1);
    chk("t1_addr", cmd_addr, 32'h1000);
    chk("t1_len", cmd_len, 63);
    chk("t1_id", cmd_id, 0);
    chk("t1_ready_pulse", req0_ready, 0);
    tick();
    cmd_ready = 1'b0;
    chk("t1_cmd_drop", cmd_valid, 0);
    finish_burst();
    chk("t1_done0", req0_done, 1);
    chk("t1_done1", req1_done, 0);
    tick();
    chk("t1_done_pulse", req0_done, 0);
    chk("t1_idle", busy, 0);

    // 150 beats split by MAX_BURST
    request(1'b0, 32'h0, 16'd150);
    expect_cmd("t2_b0", 32'h000, 8'd63, 1'b0);
    finish_burst();
    chk("t2_no_early_done", req0_done, 0);
    expect_cmd("t2_b1", 32'h200, 8'd63, 1'b0);
    finish_burst();
    expect_cmd("t2_b2", 32'h400, 8'd21, 1'b0);
    finish_burst();
    chk("t2_done", req0_done, 1);
    tick();
    chk("t2_done_pulse", req0_done, 0);

    // 4 KB boundary split for requester 1 (unaligned low bits dropped)
    request(1'b1, 32'h0FC5, 16'd20);
    expect_cmd("t3_b0", 32'h0FC0, 8'd7, 1'b1);
    finish_burst();
    expect_cmd("t3_b1", 32'h1000, 8'd11, 1'b1);
    finish_burst();
    chk("t3_done1", req1_done, 1);
    chk("t3_done0", req0_done, 0);
    tick();

    // Round robin with both requesters held valid
    req0_valid = 1'b1; req0_addr = 32'h2000; req0_beats = 16'd8;
    req1_valid = 1'b1; req1_addr = 32'h3000; req1_beats = 16'd8;
    for (int r = 0; r < 3; r++) begin
      logic exp_id;
      exp_id = (r == 1);
      tick();
      chk("rr_ready0", req0_ready, !exp_id);
      chk("rr_ready1", req1_ready, exp_id);
      tick();
      expect_cmd("rr_cmd", exp_id ? 32'h3000 : 32'h2000, 8'd7, exp_id);
      finish_burst();
      chk("rr_done0", req0_done, !exp_id);
      chk("rr_done1", req1_done, exp_id);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk_idle_outputs("rr_end");

    // Zero-beat transfer: ready then done, never a command
    request(1'b0, 32'h5000, 16'd0);
    chk("t5_cmdv", cmd_valid, 0);
    chk("t5_done", req0_done, 1);
    tick();
    chk("t5_cmdv2", cmd_valid, 0);
    chk("t5_done_pulse", req0_done, 0);

    // Reset during WAIT abandons the transfer
    request(1'b0, 32'h0, 16'd150);
    expect_cmd("t6_b0", 32'h000, 8'd63, 1'b0);
    tick();
    i_rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_rst");
    chk("t6_rst_addr", cmd_addr, 0);
    chk("t6_rst_len", cmd_len, 0);
    burst_done = 1'b1;
    tick();
    burst_done = 1'b0;
    chk_idle_outputs("t6_rst_hold");
    i_rst_n = 1'b1;
    tick();
    chk_idle_outputs("t6_post");
    request(1'b0, 32'h8000, 16'd16);
    expect_cmd("t6_new", 32'h8000, 8'd15, 1'b0);
    finish_burst();
    chk("t6_done", req0_done, 1);
    tick();
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
